// File: rtl/ga_pkg.sv
// ---------------------------------------------------------------------------
// ga_pkg
// Shared types and constants for the GA evaluation slice: scheduler state
// encoding, fitness width and the "worst possible fitness" sentinel used to
// seed best-individual tracking at the start of every generation.
// ---------------------------------------------------------------------------
package ga_pkg;

    localparam int NUM_OUT_BITS = 8;
    localparam int ERR_SUM_W    = 32;
    localparam int FITNESS_W    = 35;

    typedef logic [FITNESS_W-1:0] fitness_t;

    localparam fitness_t FITNESS_WORST = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_READY,
        START,
        WAIT_DONE,
        ACK,
        REPORT,
        FINISH
    } schedState_t;

endpackage

// File: rtl/fitness_reducer.sv
// ---------------------------------------------------------------------------
// fitness_reducer
// Combinational adder tree collapsing the eight per-output-bit error sums of
// one chromosome into a single scalar fitness. Each tree level widens by one
// bit, so the 35-bit result can never overflow (8 x 32-bit operands).
//
// Ports:
//   iErrorSums  in   8 x 32  per-output-bit error counts from the evaluator
//   oFitness    out  35      sum of all eight error counts
// ---------------------------------------------------------------------------
module fitness_reducer
    import ga_pkg::*;
(
    input  logic [NUM_OUT_BITS-1:0][ERR_SUM_W-1:0] iErrorSums,
    output fitness_t                               oFitness
);

    logic [ERR_SUM_W:0]   level1 [4];
    logic [ERR_SUM_W+1:0] level2 [2];

    // Three-level pairwise tree sized for exactly eight operands.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            level1[i] = {1'b0, iErrorSums[2*i]} + {1'b0, iErrorSums[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            level2[i] = {1'b0, level1[2*i]} + {1'b0, level1[2*i+1]};
        end
        oFitness = {1'b0, level2[0]} + {1'b0, level2[1]};
    end

endmodule

// File: rtl/population_eval_scheduler.sv
// ---------------------------------------------------------------------------
// population_eval_scheduler
// Walks a single chromosome evaluator across individuals 0..Neff-1 of the
// stored population. For each individual it selects the description, lets
// the description memory settle for LOAD_LATENCY cycles, runs one
// start/done/feedback handshake with the evaluator, reduces the error sums
// to a fitness, reports it, and tracks the lowest-fitness individual.
//
// Optional feature macro: POP_EVAL_EARLY_STOP_EN
//   defined   - a reported fitness of 0 ends the generation immediately
//   undefined - every one of the Neff individuals is evaluated
//
// Ports:
//   iClock, iReset_n     clock, asynchronous active-low reset
//   iStartGeneration     one-cycle start request (ignored unless idle)
//   iPopulationSize      requested N, clamped to POP_SIZE
//   oBusy                generation in progress
//   oGenerationDone      one-cycle end-of-generation pulse
//   oChromIndex          description select for the evaluator
//   oEvalStart           evaluator start request
//   iEvalReady           evaluator idle
//   iEvalDone            evaluator finished
//   oEvalDoneFeedback    acknowledge of iEvalDone
//   iErrorSums           8 x 32-bit per-output-bit error counts
//   oFitnessValid        one-cycle pulse per evaluated individual
//   oFitness             fitness of individual oFitnessIndex
//   oFitnessIndex        index of the reported individual
//   oBestIndex           lowest-fitness individual so far
//   oBestFitness         fitness of oBestIndex
// ---------------------------------------------------------------------------
module population_eval_scheduler
    import ga_pkg::*;
#(
    parameter int POP_SIZE     = 16,
    parameter int IDX_W        = 8,
    parameter int LOAD_LATENCY = 2
) (
    input  logic                                   iClock,
    input  logic                                   iReset_n,
    input  logic                                   iStartGeneration,
    input  logic [IDX_W-1:0]                       iPopulationSize,
    output logic                                   oBusy,
    output logic                                   oGenerationDone,
    output logic [IDX_W-1:0]                       oChromIndex,
    output logic                                   oEvalStart,
    input  logic                                   iEvalReady,
    input  logic                                   iEvalDone,
    output logic                                   oEvalDoneFeedback,
    input  logic [NUM_OUT_BITS-1:0][ERR_SUM_W-1:0] iErrorSums,
    output logic                                   oFitnessValid,
    output fitness_t                               oFitness,
    output logic [IDX_W-1:0]                       oFitnessIndex,
    output logic [IDX_W-1:0]                       oBestIndex,
    output fitness_t                               oBestFitness
);

    localparam int               CNT_W     = 4;
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_LATENCY - 1);
    localparam logic [IDX_W:0]   POP_LIMIT = (IDX_W + 1)'(POP_SIZE);
    localparam logic [IDX_W-1:0] POP_LAST  = IDX_W'(POP_SIZE - 1);

    schedState_t      stateQ,    stateD;
    logic [IDX_W-1:0] idxQ,      idxD;
    logic [IDX_W-1:0] lastIdxQ,  lastIdxD;
    logic [CNT_W-1:0] loadCntQ,  loadCntD;
    fitness_t         fitnessQ,  fitnessD;
    logic [IDX_W-1:0] bestIdxQ,  bestIdxD;
    fitness_t         bestFitQ,  bestFitD;
    logic             busyQ,     busyD;
    logic             genDoneQ,  genDoneD;

    fitness_t         reducedFitness;
    logic             earlyStop;
    logic             sizeClamped;

    fitness_reducer uReducer (
        .iErrorSums (iErrorSums),
        .oFitness   (reducedFitness)
    );

`ifdef POP_EVAL_EARLY_STOP_EN
    assign earlyStop = (fitnessQ == '0);
`else
    assign earlyStop = 1'b0;
`endif

    // Neff = min(N, POP_SIZE); only Neff-1 is kept since it is what REPORT compares.
    assign sizeClamped = ({1'b0, iPopulationSize} > POP_LIMIT);

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            stateQ   <= IDLE;
            idxQ     <= '0;
            lastIdxQ <= '0;
            loadCntQ <= '0;
            fitnessQ <= '0;
            bestIdxQ <= '0;
            bestFitQ <= FITNESS_WORST;
            busyQ    <= 1'b0;
            genDoneQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            idxQ     <= idxD;
            lastIdxQ <= lastIdxD;
            loadCntQ <= loadCntD;
            fitnessQ <= fitnessD;
            bestIdxQ <= bestIdxD;
            bestFitQ <= bestFitD;
            busyQ    <= busyD;
            genDoneQ <= genDoneD;
        end
    end

    // Busy and generation-done are registered, so both settle one cycle after
    // the state that decides them; handshake strobes are decoded from state.
    always_comb begin
        stateD            = stateQ;
        idxD              = idxQ;
        lastIdxD          = lastIdxQ;
        loadCntD          = loadCntQ;
        fitnessD          = fitnessQ;
        bestIdxD          = bestIdxQ;
        bestFitD          = bestFitQ;
        busyD             = busyQ;
        genDoneD          = 1'b0;
        oEvalStart        = 1'b0;
        oEvalDoneFeedback = 1'b0;
        oFitnessValid     = 1'b0;

        case (stateQ)
            IDLE: begin
                if (iStartGeneration) begin
                    busyD = 1'b1;
                    if (iPopulationSize == '0) begin
                        stateD = FINISH;
                    end else begin
                        idxD     = '0;
                        lastIdxD = sizeClamped ? POP_LAST : (iPopulationSize - IDX_W'(1));
                        bestIdxD = '0;
                        bestFitD = FITNESS_WORST;
                        loadCntD = '0;
                        stateD   = LOAD;
                    end
                end
            end

            LOAD: begin
                if (loadCntQ == LOAD_LAST) begin
                    loadCntD = '0;
                    stateD   = WAIT_READY;
                end else begin
                    loadCntD = loadCntQ + CNT_W'(1);
                end
            end

            WAIT_READY: begin
                if (iEvalReady) begin
                    stateD = START;
                end
            end

            START: begin
                oEvalStart = 1'b1;
                stateD     = WAIT_DONE;
            end

            WAIT_DONE: begin
                if (iEvalDone) begin
                    fitnessD = reducedFitness;
                    stateD   = ACK;
                end
            end

            ACK: begin
                oEvalDoneFeedback = 1'b1;
                if (!iEvalDone) begin
                    stateD = REPORT;
                end
            end

            REPORT: begin
                oFitnessValid = 1'b1;
                // Strict compare: on a tie the earlier (lower) index stays best.
                if (fitnessQ < bestFitQ) begin
                    bestFitD = fitnessQ;
                    bestIdxD = idxQ;
                end
                if ((idxQ == lastIdxQ) || earlyStop) begin
                    stateD = FINISH;
                end else begin
                    idxD     = idxQ + IDX_W'(1);
                    loadCntD = '0;
                    stateD   = LOAD;
                end
            end

            FINISH: begin
                genDoneD = 1'b1;
                busyD    = 1'b0;
                stateD   = IDLE;
            end

            default: begin
                stateD = IDLE;
            end
        endcase
    end

    assign oBusy           = busyQ;
    assign oGenerationDone = genDoneQ;
    assign oChromIndex     = idxQ;
    assign oFitness        = fitnessQ;
    assign oFitnessIndex   = idxQ;
    assign oBestIndex      = bestIdxQ;
    assign oBestFitness    = bestFitQ;

endmodule

// File: tb/tb_population_eval_scheduler.sv
// ---------------------------------------------------------------------------
// tb_population_eval_scheduler
// Directed bench for population_eval_scheduler. The evaluator is modelled by
// driving iEvalReady/iEvalDone/iErrorSums from the stimulus sequence; all
// expected fitness values are hand-computed sums of the applied error counts.
// ---------------------------------------------------------------------------
module tb_population_eval_scheduler;

    localparam int IDX_W = 8;

    logic                  iClock;
    logic                  iReset_n;
    logic                  iStartGeneration;
    logic [IDX_W-1:0]      iPopulationSize;
    logic                  oBusy;
    logic                  oGenerationDone;
    logic [IDX_W-1:0]      oChromIndex;
    logic                  oEvalStart;
    logic                  iEvalReady;
    logic                  iEvalDone;
    logic                  oEvalDoneFeedback;
    logic [7:0][31:0]      iErrorSums;
    logic                  oFitnessValid;
    logic [34:0]           oFitness;
    logic [IDX_W-1:0]      oFitnessIndex;
    logic [IDX_W-1:0]      oBestIndex;
    logic [34:0]           oBestFitness;

    int checks = 0;
    int errors = 0;
    int evalCount = 0;

    population_eval_scheduler #(
        .POP_SIZE     (16),
        .IDX_W        (IDX_W),
        .LOAD_LATENCY (2)
    ) dut (
        .iClock            (iClock),
        .iReset_n          (iReset_n),
        .iStartGeneration  (iStartGeneration),
        .iPopulationSize   (iPopulationSize),
        .oBusy             (oBusy),
        .oGenerationDone   (oGenerationDone),
        .oChromIndex       (oChromIndex),
        .oEvalStart        (oEvalStart),
        .iEvalReady        (iEvalReady),
        .iEvalDone         (iEvalDone),
        .oEvalDoneFeedback (oEvalDoneFeedback),
        .iErrorSums        (iErrorSums),
        .oFitnessValid     (oFitnessValid),
        .oFitness          (oFitness),
        .oFitnessIndex     (oFitnessIndex),
        .oBestIndex        (oBestIndex),
        .oBestFitness      (oBestFitness)
    );

    // Free-running 10-unit clock.
    initial begin
        iClock = 1'b0;
        forever #5 iClock = ~iClock;
    end

    // Hard stop in case something upstream loops forever.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one cycle; values are observed and driven 1 unit after the edge.
    task automatic stepCycle();
        @(posedge iClock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One-cycle start request; returns in the cycle after acceptance.
    task automatic applyStimulus(input logic [IDX_W-1:0] popSize);
        iStartGeneration = 1'b1;
        iPopulationSize  = popSize;
        stepCycle();
        iStartGeneration = 1'b0;
    endtask

    // Steps until oEvalStart is seen (bounded) and checks the selected index.
    task automatic waitEvalStart(input logic [IDX_W-1:0] expIdx);
        int n = 0;
        while (oEvalStart !== 1'b1 && n < 50) begin
            stepCycle();
            n++;
        end
        checkOutput("evalStartSeen", 64'(oEvalStart), 64'd1);
        checkOutput("chromIndex", 64'(oChromIndex), 64'(expIdx));
        if (oEvalStart === 1'b1) evalCount++;
    endtask

    // Called in the START cycle. Holds iEvalDone for holdCycles cycles, then
    // checks the feedback window and the single fitness report.
    task automatic runEval(input logic [7:0][31:0] sums, input int holdCycles,
                           input logic [34:0] expFit, input logic [IDX_W-1:0] expIdx);
        stepCycle();
        checkOutput("evalStartOneCycle", 64'(oEvalStart), 64'd0);
        iEvalDone  = 1'b1;
        iErrorSums = sums;
        for (int i = 0; i < holdCycles; i++) begin
            stepCycle();
            checkOutput("feedbackHigh", 64'(oEvalDoneFeedback), 64'd1);
            checkOutput("noEarlyReport", 64'(oFitnessValid), 64'd0);
        end
        iEvalDone  = 1'b0;
        iErrorSums = '0;
        stepCycle();
        checkOutput("fitnessValid", 64'(oFitnessValid), 64'd1);
        checkOutput("fitness", 64'(oFitness), 64'(expFit));
        checkOutput("fitnessIndex", 64'(oFitnessIndex), 64'(expIdx));
        checkOutput("feedbackLow", 64'(oEvalDoneFeedback), 64'd0);
        stepCycle();
        checkOutput("fitnessValidPulse", 64'(oFitnessValid), 64'd0);
    endtask

    // Called in the FINISH cycle; checks the done pulse and best result.
    task automatic checkGenerationEnd(input logic [IDX_W-1:0] expBestIdx, input logic [34:0] expBestFit);
        checkOutput("doneNotYet", 64'(oGenerationDone), 64'd0);
        checkOutput("busyInFinish", 64'(oBusy), 64'd1);
        stepCycle();
        checkOutput("generationDone", 64'(oGenerationDone), 64'd1);
        checkOutput("busyDropped", 64'(oBusy), 64'd0);
        checkOutput("bestIndex", 64'(oBestIndex), 64'(expBestIdx));
        checkOutput("bestFitness", 64'(oBestFitness), 64'(expBestFit));
        stepCycle();
        checkOutput("donePulse", 64'(oGenerationDone), 64'd0);
    endtask

    task automatic checkResetValues();
        checkOutput("rstBusy", 64'(oBusy), 64'd0);
        checkOutput("rstDone", 64'(oGenerationDone), 64'd0);
        checkOutput("rstChromIndex", 64'(oChromIndex), 64'd0);
        checkOutput("rstEvalStart", 64'(oEvalStart), 64'd0);
        checkOutput("rstFeedback", 64'(oEvalDoneFeedback), 64'd0);
        checkOutput("rstFitnessValid", 64'(oFitnessValid), 64'd0);
        checkOutput("rstFitness", 64'(oFitness), 64'd0);
        checkOutput("rstFitnessIndex", 64'(oFitnessIndex), 64'd0);
        checkOutput("rstBestIndex", 64'(oBestIndex), 64'd0);
        checkOutput("rstBestFitness", 64'(oBestFitness), 64'h7_FFFF_FFFF);
    endtask

    initial begin
        logic [7:0][31:0] s;

        iReset_n         = 1'b0;
        iStartGeneration = 1'b0;
        iPopulationSize  = '0;
        iEvalReady       = 1'b1;
        iEvalDone        = 1'b0;
        iErrorSums       = '0;

        stepCycle();
        stepCycle();
        checkResetValues();
        iReset_n = 1'b1;
        stepCycle();

        // Empty generation: done two cycles after the start, no evaluation.
        $display("[TB] empty generation");
        applyStimulus(8'd0);
        checkOutput("n0Busy", 64'(oBusy), 64'd1);
        checkOutput("n0EvalStartT1", 64'(oEvalStart), 64'd0);
        checkOutput("n0DoneT1", 64'(oGenerationDone), 64'd0);
        stepCycle();
        checkOutput("n0DoneT2", 64'(oGenerationDone), 64'd1);
        checkOutput("n0BusyT2", 64'(oBusy), 64'd0);
        checkOutput("n0EvalStartT2", 64'(oEvalStart), 64'd0);
        checkOutput("n0BestFitness", 64'(oBestFitness), 64'h7_FFFF_FFFF);

        // Three individuals with exact start latency; the last holds done for 5 cycles.
        $display("[TB] three individuals");
        applyStimulus(8'd3);
        checkOutput("t1Busy", 64'(oBusy), 64'd1);
        checkOutput("t1ChromIndex", 64'(oChromIndex), 64'd0);
        checkOutput("t1EvalStart", 64'(oEvalStart), 64'd0);
        iStartGeneration = 1'b1;
        iPopulationSize  = 8'd0;
        stepCycle();
        iStartGeneration = 1'b0;
        checkOutput("t2EvalStart", 64'(oEvalStart), 64'd0);
        stepCycle();
        checkOutput("t3EvalStart", 64'(oEvalStart), 64'd0);
        stepCycle();
        checkOutput("t4EvalStart", 64'(oEvalStart), 64'd1);
        s = '0; s[0] = 32'd1;
        runEval(s, 1, 35'd1, 8'd0);
        waitEvalStart(8'd1);
        s = '0; s[2] = 32'd2; s[7] = 32'd3;
        runEval(s, 1, 35'd5, 8'd1);
        waitEvalStart(8'd2);
        s = '0; s[7] = 32'd1;
        runEval(s, 5, 35'd1, 8'd2);
        checkGenerationEnd(8'd0, 35'd1);

        // Oversized request clamps to 16; index 0 saturates every error sum.
        $display("[TB] clamped population");
        evalCount = 0;
        applyStimulus(8'd40);
        for (int k = 0; k < 16; k++) begin
            waitEvalStart(8'(k));
            s = '0;
            if (k == 0) begin
                s = '1;
                runEval(s, 1, 35'h7_FFFF_FFF8, 8'd0);
            end else begin
                s[k % 8] = 32'(100 - k);
                runEval(s, 1, 35'(100 - k), 8'(k));
            end
        end
        checkOutput("clampEvalCount", 64'(evalCount), 64'd16);
        checkGenerationEnd(8'd15, 35'd85);

`ifdef POP_EVAL_EARLY_STOP_EN
        // A perfect individual ends the generation early.
        $display("[TB] early stop");
        evalCount = 0;
        applyStimulus(8'd4);
        waitEvalStart(8'd0);
        s = '0; s[0] = 32'd3;
        runEval(s, 1, 35'd3, 8'd0);
        waitEvalStart(8'd1);
        s = '0;
        runEval(s, 1, 35'd0, 8'd1);
        checkOutput("earlyEvalCount", 64'(evalCount), 64'd2);
        checkGenerationEnd(8'd1, 35'd0);
        for (int i = 0; i < 6; i++) begin
            stepCycle();
            checkOutput("earlyNoMoreStarts", 64'(oEvalStart), 64'd0);
        end
`else
        // Without early stop a perfect individual does not end the generation.
        $display("[TB] zero fitness without early stop");
        evalCount = 0;
        applyStimulus(8'd2);
        waitEvalStart(8'd0);
        s = '0;
        runEval(s, 1, 35'd0, 8'd0);
        waitEvalStart(8'd1);
        s = '0; s[1] = 32'd4;
        runEval(s, 1, 35'd4, 8'd1);
        checkOutput("fullEvalCount", 64'(evalCount), 64'd2);
        checkGenerationEnd(8'd0, 35'd0);
`endif

        // Reset while index 1 waits for done, then a clean restart from index 0.
        $display("[TB] reset mid-generation");
        applyStimulus(8'd3);
        waitEvalStart(8'd0);
        s = '0; s[0] = 32'd1;
        runEval(s, 1, 35'd1, 8'd0);
        waitEvalStart(8'd1);
        stepCycle();
        iReset_n = 1'b0;
        stepCycle();
        checkResetValues();
        iReset_n = 1'b1;
        stepCycle();
        applyStimulus(8'd1);
        checkOutput("restartBusy", 64'(oBusy), 64'd1);
        checkOutput("restartChromIndex", 64'(oChromIndex), 64'd0);
        waitEvalStart(8'd0);
        s = '0; s[3] = 32'd7;
        runEval(s, 1, 35'd7, 8'd0);
        checkGenerationEnd(8'd0, 35'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/population_eval_scheduler.md
# population_eval_scheduler

Sequences one chromosome evaluator across a population of stored chromosomes. Per chromosome it selects the description, waits for the description memory to settle, runs one evaluation, and collapses the eight per-bit error sums into a scalar fitness. It tracks the best (lowest-error) individual of the generation. It sits between the GA host/controller and the chromosome processing state machine, driving that machine's start/done-feedback handshake.

## Interface
Parameters:
- POP_SIZE, 16: maximum individuals per generation.
- IDX_W, 8: index width; POP_SIZE ≤ 2^IDX_W.
- LOAD_LATENCY, 2: cycles from oChromIndex change to a valid description at the evaluator; legal range 1..15.

Ports:
- iClock  in  1  system clock.
- iReset_n  in  1  asynchronous, active-low reset.
- iStartGeneration  in  1  single-cycle request to evaluate individuals 0..N-1.
- iPopulationSize  in  IDX_W  N, sampled on an accepted start.
- oBusy  out  1  high from the accepted start until the oGenerationDone cycle.
- oGenerationDone  out  1  one-cycle pulse.
- oChromIndex  out  IDX_W  selects the description fed to the evaluator.
- oEvalStart  out  1  evaluator start request.
- iEvalReady  in  1  evaluator idle.
- iEvalDone  in  1  evaluator finished.
- oEvalDoneFeedback  out  1  evaluator acknowledge.
- iErrorSums  in  8×32  evaluator per-output-bit error counts.
- oFitnessValid  out  1  one-cycle pulse per individual.
- oFitness  out  35  sum of the 8 error sums for the individual in oFitnessIndex.
- oFitnessIndex  out  IDX_W  index of the reported individual.
- oBestIndex  out  IDX_W  lowest-fitness individual of the generation.
- oBestFitness  out  35  fitness of oBestIndex.

## Operation
- States: IDLE, LOAD, WAIT_READY, START, WAIT_DONE, ACK, REPORT, FINISH.
- IDLE: on iStartGeneration, latch Neff = min(N, POP_SIZE).
  - If Neff = 0: go to FINISH.
  - Otherwise: set index = 0, best fitness = all-ones, best index = 0, then go to LOAD.
- LOAD: a counter runs LOAD_LATENCY cycles with oChromIndex = index, then goes to WAIT_READY.
- WAIT_READY: when iEvalReady = 1, go to START.
- START: oEvalStart = 1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE: on iEvalDone = 1, capture fitness = zero-extended sum of the 8 error sums (35-bit, no overflow), then go to ACK.
- ACK: oEvalDoneFeedback stays high until iEvalDone falls, then goes to REPORT.
- REPORT: pulse oFitnessValid with the captured fitness and index.
  - Update best only on strictly lower fitness, so ties keep the lower index.
  - If index = Neff-1, go to FINISH; else increment index and go to LOAD.
- FINISH: pulse oGenerationDone, drop oBusy, return to IDLE.
- iStartGeneration outside IDLE is ignored.
- oChromIndex holds its value outside LOAD.
- oBestIndex/oBestFitness hold until the next accepted start, where they are reinitialised.

## Timing
- Reset values: all outputs 0, except oBestFitness = all-ones. State = IDLE.
- Start accepted in cycle T: oBusy = 1 at T+1; oChromIndex valid at T+1.
- With iEvalReady already high, oEvalStart asserts at T+1+LOAD_LATENCY+1.
- iEvalDone seen in cycle D: oEvalDoneFeedback = 1 at D+1. After iEvalDone falls in cycle F, oFitnessValid pulses at F+1.
- The next individual's LOAD begins the cycle after REPORT.
- Neff = 0: oGenerationDone at T+2; no oEvalStart issued.
- iEvalDone and iEvalReady high in the same cycle: iEvalDone takes priority in WAIT_DONE only.
- Reset asserted mid-generation: immediate return to reset values. The evaluator shares iReset_n and restarts cleanly.

## Configuration
- POP_EVAL_EARLY_STOP_EN defined:
  - A REPORT with fitness = 0 goes directly to FINISH.
  - Remaining individuals are skipped; oBestIndex is the perfect individual.
- Not defined: all Neff individuals are always evaluated.

## Structure
- Shared package ga_pkg holds:
  - state enum;
  - FITNESS_W = 35;
  - NUM_OUT_BITS = 8;
  - fitness_t typedef;
  - FITNESS_WORST constant.
- One sub-module: fitness_reducer (combinational 8×32 → 35-bit adder tree). The scheduler registers its output in WAIT_DONE.

## Test plan
- N=3, LOAD_LATENCY=2, evaluator model returns sums {1,0,0,0,0,0,0,0}, {0,0,2,0,0,0,0,3}, {0,0,0,0,0,0,0,1} → fitness pulses 1, 5, 1 for indices 0, 1, 2; best = index 0, fitness 1 (tie kept); one oGenerationDone.
- N=0 → oGenerationDone at T+2, oEvalStart never asserted, best fitness all-ones.
- N=40 with POP_SIZE=16 → exactly 16 evaluations, last oFitnessIndex = 15.
- Evaluator holds iEvalDone for 5 cycles → oEvalDoneFeedback high for those cycles; a single oFitnessValid one cycle after iEvalDone falls.
- Reset asserted while in WAIT_DONE of index 1 → all outputs at reset values next edge; a fresh start afterwards runs from index 0.
- POP_EVAL_EARLY_STOP_EN, N=4, fitness 0 at index 1 → only 2 evaluations; best = index 1, fitness 0.
